// File: rtl/cm0_dap_sw_cdc_hs_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dap_sw_cdc_hs_rx_pkg
// Brief    : Shared types and constants for the DAP serial-wire CDC
//            handshake receiver (FSM encoding, DATAOUT reset pattern,
//            synchroniser depth limits).
// Revision : 1.0  initial release
// ============================================================================
package cm0_dap_sw_cdc_hs_rx_pkg;

  // Receive handshake FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CAPT = 2'b01,
    ST_HOLD = 2'b10,
    ST_ACKH = 2'b11
  } state_t;

  // DATAOUT resets to all ones; replicated to DW at the use site
  localparam logic c_dout_rst_bit = 1'b1;

  // Legal synchroniser depths
  localparam int c_sync_min = 2;
  localparam int c_sync_max = 3;

  // Forces an out-of-range depth into the legal window so that a bad
  // parameter can never build a 0- or 1-flop synchroniser
  function automatic int clamp_sync(input int n);
    if (n < c_sync_min) return c_sync_min;
    if (n > c_sync_max) return c_sync_max;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cm0_dap_sw_cdc_sync.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dap_sw_cdc_sync
// Brief    : Multi-flop level synchroniser, reset value 0. Scan enable is
//            carried through the port list only; it has no functional use.
// Revision : 1.0  initial release
// ============================================================================
module cm0_dap_sw_cdc_sync
  import cm0_dap_sw_cdc_hs_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic i_regclk,
  input  logic i_regresetn,
  input  logic i_se,
  input  logic i_d,
  output logic o_q
);

  localparam int c_stages = clamp_sync(STAGES);

  logic [c_stages-1:0] r_sync;
  logic                w_unused_se;

  assign w_unused_se = i_se;

  // Shift the asynchronous level through the synchroniser chain
  always_ff @(posedge i_regclk or negedge i_regresetn) begin
    if (!i_regresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[c_stages-2:0], i_d};
    end
  end

  assign o_q = r_sync[c_stages-1];

endmodule
`default_nettype wire

// File: rtl/cm0_dap_sw_cdc_hs_rx.sv
`default_nettype none
// ============================================================================
// Module   : cm0_dap_sw_cdc_hs_rx
// Brief    : Receive-side controller of a 4-phase REQ/ACK clock-domain
//            crossing. Synchronises REQ, pulses CAPTEN for one cycle to
//            capture DATAIN, offers the data on a valid/ready interface and
//            returns ACK once the consumer has accepted it.
//            Optional macro CM0_DAP_SW_CDC_HS_ERR_EN adds a sticky ERR flag
//            raised when REQ is seen low during CAPT or HOLD.
// Revision : 1.0  initial release
// ============================================================================
module cm0_dap_sw_cdc_hs_rx
  import cm0_dap_sw_cdc_hs_rx_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_regclk,
  input  logic          i_regresetn,
  input  logic          i_se,
  input  logic          i_req,
  input  logic [DW-1:0] i_datain,
  output logic          o_ack,
  output logic          o_capten,
  output logic          o_dvalid,
  input  logic          i_dready,
  output logic [DW-1:0] o_dataout,
  output logic          o_err
);

  generate
    if (PRESENT != 0) begin : g_present

      state_t          r_state;
      state_t          w_next;
      logic            w_req_s;
      logic            r_ack;
      logic            r_capten;
      logic            r_dvalid;
      logic [DW-1:0]   r_dout;
      logic            w_err;

      cm0_dap_sw_cdc_sync #(
        .STAGES (SYNC_STAGES)
      ) u_req_sync (
        .i_regclk    (i_regclk),
        .i_regresetn (i_regresetn),
        .i_se        (i_se),
        .i_d         (i_req),
        .o_q         (w_req_s)
      );

      // Handshake FSM state register
      always_ff @(posedge i_regclk or negedge i_regresetn) begin
        if (!i_regresetn) begin
          r_state <= ST_IDLE;
        end else begin
          r_state <= w_next;
        end
      end

      // Next-state decode; CAPT is always followed by HOLD so a started
      // transfer completes locally even if REQ drops early
      always_comb begin
        w_next = r_state;
        case (r_state)
          ST_IDLE: if (w_req_s)               w_next = ST_CAPT;
          ST_CAPT:                            w_next = ST_HOLD;
          ST_HOLD: if (r_dvalid && i_dready)  w_next = ST_ACKH;
          ST_ACKH: if (!w_req_s)              w_next = ST_IDLE;
          default:                            w_next = ST_IDLE;
        endcase
      end

      // Outputs come straight from flops so ACK/CAPTEN are glitch-free
      always_ff @(posedge i_regclk or negedge i_regresetn) begin
        if (!i_regresetn) begin
          r_ack    <= 1'b0;
          r_capten <= 1'b0;
          r_dvalid <= 1'b0;
        end else begin
          r_ack    <= (w_next == ST_ACKH);
          r_capten <= (w_next == ST_CAPT);
          r_dvalid <= (w_next == ST_HOLD);
        end
      end

      // Capture register, loaded only on the CAPTEN cycle
      always_ff @(posedge i_regclk or negedge i_regresetn) begin
        if (!i_regresetn) begin
          r_dout <= {DW{c_dout_rst_bit}};
        end else if (r_capten) begin
          r_dout <= i_datain;
        end
      end

`ifdef CM0_DAP_SW_CDC_HS_ERR_EN
      logic r_err;

      // Sticky flag: REQ withdrawn before the data was acknowledged
      always_ff @(posedge i_regclk or negedge i_regresetn) begin
        if (!i_regresetn) begin
          r_err <= 1'b0;
        end else if (((r_state == ST_CAPT) || (r_state == ST_HOLD)) && !w_req_s) begin
          r_err <= 1'b1;
        end
      end

      assign w_err = r_err;
`else
      assign w_err = 1'b0;
`endif

      assign o_ack     = r_ack;
      assign o_capten  = r_capten;
      assign o_dvalid  = r_dvalid;
      assign o_dataout = r_dout;
      assign o_err     = w_err;

    end else begin : g_absent

      logic [DW+4:0] w_unused_in;

      assign w_unused_in = {i_regclk, i_regresetn, i_se, i_req, i_dready, i_datain};

      assign o_ack     = 1'b0;
      assign o_capten  = 1'b0;
      assign o_dvalid  = 1'b0;
      assign o_dataout = '0;
      assign o_err     = 1'b0;

    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/cm0_dap_sw_cdc_hs_rx.md
Name: cm0_dap_sw_cdc_hs_rx

Overview:
- Receive-side controller for a 4-phase request/acknowledge clock-domain crossing in the DAP serial-wire path.
- Synchronises an asynchronous REQ level from the source domain and generates the single-cycle capture enable (CAPTEN) that drives the CDC-safe capture registers.
- Captures the source data bus, presents it to the local consumer with a valid/ready handshake, and returns ACK to the source only after the consumer has accepted the data.

Parameters:
- PRESENT, 1: 0 removes the block; all outputs tied to reset values except DATAOUT and CAPTEN, which are tied to 0.
- DW, 32: width of DATAIN/DATAOUT.
- SYNC_STAGES, 2: flops in the REQ synchroniser; legal values 2 or 3.

Ports:
- REGCLK  in  1  register clock
- REGRESETn  in  1  reset, asynchronous assert, active-low
- SE  in  1  scan enable, passed to the synchroniser only; no functional effect
- REQ  in  1  asynchronous request level from the source domain
- DATAIN  in  DW  source data; stable while REQ is high and ACK is low
- ACK  out  1  acknowledge level to the source domain, driven from a flop
- CAPTEN  out  1  one-cycle capture enable for external capture registers
- DVALID  out  1  captured data valid to the local consumer
- DREADY  in  1  consumer accept
- DATAOUT  out  DW  captured data
- ERR  out  1  sticky protocol error (optional feature only; 0 otherwise)

Behaviour:
- Reset values: ACK=0, CAPTEN=0, DVALID=0, DATAOUT=all ones, ERR=0, FSM in IDLE, synchroniser=0.
- req_s is REQ after SYNC_STAGES flops.
- FSM states: IDLE, CAPT, HOLD, ACKH.
- IDLE: when req_s=1, go to CAPT.
- CAPT: lasts exactly one cycle. CAPTEN=1. DATAOUT<=DATAIN on this edge; DATAOUT is loaded only when CAPTEN=1. Next state is HOLD.
- HOLD: DVALID=1. When DVALID=1 and DREADY=1, go to ACKH and set ACK=1 on the next edge.
- ACKH: ACK=1. When req_s=0, ACK<=0 and return to IDLE.
- Latency: REQ rise to CAPTEN high is SYNC_STAGES+1 cycles. CAPTEN to DVALID high is 1 cycle. Accept to ACK high is 1 cycle. req_s fall to ACK low is 1 cycle.
- DREADY is ignored whenever DVALID=0. DREADY held permanently high gives the minimum round trip.
- REQ pulse shorter than the synchroniser resolves: no capture if req_s never goes high. Once CAPT is entered, the transfer always completes locally.
- REQ falling during CAPT or HOLD is a protocol violation. FSM still completes HOLD, enters ACKH, sees req_s=0 and returns to IDLE with ACK high for exactly 1 cycle.
- A new REQ rise is not recognised until the FSM is back in IDLE with req_s=1, so there is no back-to-back capture without an ACK cycle.
- DATAOUT holds its value after the transfer until the next CAPT, regardless of DATAIN changes.
- Reset asserted mid-transfer returns all state to reset values immediately. The source sees ACK=0 and must restart the transfer.

Optional Feature:
- Macro: CM0_DAP_SW_CDC_HS_ERR_EN
- With the macro: ERR is set sticky when req_s=0 is observed in CAPT or HOLD. It is cleared only by reset. Handshake behaviour is unchanged.
- Without the macro: ERR is tied to 0 and no detection logic is present.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'b00, CAPT=2'b01, HOLD=2'b10, ACKH=2'b11.
  - DATAOUT reset constant (all ones).
  - SYNC_STAGES legal-range constants.
- One sub-module: cm0_dap_sw_cdc_sync, a parameterised multi-flop level synchroniser (REGCLK, REGRESETn, SE, D, Q) with reset value 0. It is instantiated once for REQ.

Test Plan:
- Reset, then idle with REQ=0: ACK=0, DVALID=0, CAPTEN=0, DATAOUT=32'hFFFFFFFF.
- SYNC_STAGES=2, DREADY tied 1, DATAIN=32'hA5A5_0F0F, raise REQ: CAPTEN high at cycle 3; DATAOUT=32'hA5A50F0F at cycle 4; ACK high at cycle 5. Drop REQ: ACK low 3 cycles later.
- Backpressure: DREADY=0 for 10 cycles after DVALID. DVALID and DATAOUT stay stable, ACK stays 0, CAPTEN pulses once. DREADY=1 gives ACK one cycle later.
- Change DATAIN to 32'h1234_5678 while in HOLD and after ACK: DATAOUT stays 32'hA5A50F0F until the next capture.
- Assert REGRESETn low during HOLD: ACK=0, DVALID=0, DATAOUT=all ones in the same cycle. A new REQ completes normally.
- With CM0_DAP_SW_CDC_HS_ERR_EN, drop REQ during HOLD: ERR=1 and stays 1. ACK pulses for 1 cycle, FSM returns to IDLE. Without the macro, ERR=0 throughout.
